pwm_duty_decoder: RTL



---
 rtl/pwm_duty_decoder.sv | 123 ++++++++++++
 1 files changed

// File: rtl/pwm_duty_decoder.sv
// Measures high time and period of a 4-bit PWM waveform in CE ticks, recovers
// the duty word and flags stuck-low, stuck-high and non-16-tick periods.
//
// state | meaning
// IDLE  | no measurement in progress; waiting for a rising edge
// HIGH  | rising edge seen, input still high, counting high ticks
// LOW   | input has fallen; next rising edge closes the period
module pwm_duty_decoder #(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 48
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CE,
    input  logic             PWM_IN,
    output logic [3:0]       D_OUT,
    output logic [CNT_W-1:0] HIGH_CNT,
    output logic [CNT_W-1:0] PERIOD,
    output logic             VALID,
    output logic             STUCK_LO,
    output logic             STUCK_HI,
    output logic             FMT_ERR
);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);
    localparam logic [CNT_W-1:0] FIFTEEN = CNT_W'(15);
    localparam logic [CNT_W-1:0] SIXTEEN = CNT_W'(16);
    localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);

    state_t           state_q;
    logic             sync1_q, sync2_q, prev_q;
    logic [CNT_W-1:0] hcnt_q, pcnt_q;
    logic [CNT_W-1:0] high_cnt_q, period_q;
    logic [3:0]       d_out_q;
    logic             valid_q, stuck_lo_q, stuck_hi_q, fmt_err_q;

    logic             s, rise, timeout, fmt_ok;
    logic [CNT_W-1:0] hcnt_d, pcnt_d;

    always_comb begin
        s       = sync2_q;
        rise    = s & ~prev_q;
        pcnt_d  = (pcnt_q == CNT_MAX) ? pcnt_q : pcnt_q + ONE;
        hcnt_d  = (hcnt_q == CNT_MAX) ? hcnt_q : hcnt_q + ONE;
        // Once stuck and idle, the saturating counter must not re-fire the timeout
        timeout = (pcnt_d == TO_VAL) && !((state_q == IDLE) && (stuck_lo_q | stuck_hi_q));
        fmt_ok  = (pcnt_q == SIXTEEN) && (hcnt_q >= TWO) && (hcnt_q <= FIFTEEN);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            prev_q     <= 1'b0;
            hcnt_q     <= '0;
            pcnt_q     <= '0;
            high_cnt_q <= '0;
            period_q   <= '0;
            d_out_q    <= 4'h0;
            valid_q    <= 1'b0;
            stuck_lo_q <= 1'b0;
            stuck_hi_q <= 1'b0;
            fmt_err_q  <= 1'b0;
        end else begin
            sync1_q <= PWM_IN;
            sync2_q <= sync1_q;
            valid_q <= 1'b0;
            if (CE) begin
                prev_q <= s;
                if (rise) begin
                    if (state_q == LOW) begin
                        high_cnt_q <= hcnt_q;
                        period_q   <= pcnt_q;
                        valid_q    <= 1'b1;
                        stuck_lo_q <= 1'b0;
                        stuck_hi_q <= 1'b0;
                        fmt_err_q  <= ~fmt_ok;
                        if (fmt_ok) begin
                            d_out_q <= hcnt_q[3:0] - 4'd1;
                        end
                    end
                    hcnt_q  <= ONE;
                    pcnt_q  <= ONE;
                    state_q <= HIGH;
                end else if (timeout) begin
                    high_cnt_q <= '0;
                    period_q   <= '0;
                    fmt_err_q  <= 1'b0;
                    valid_q    <= 1'b1;
                    stuck_lo_q <= ~s;
                    stuck_hi_q <= s;
                    d_out_q    <= s ? 4'hF : 4'h0;
                    hcnt_q     <= '0;
                    pcnt_q     <= '0;
                    state_q    <= IDLE;
                end else begin
                    pcnt_q <= pcnt_d;
                    if (state_q == HIGH) begin
                        if (s) begin
                            hcnt_q <= hcnt_d;
                        end else begin
                            state_q <= LOW;
                        end
                    end
                end
            end
        end
    end

    assign D_OUT    = d_out_q;
    assign HIGH_CNT = high_cnt_q;
    assign PERIOD   = period_q;
    assign VALID    = valid_q;
    assign STUCK_LO = stuck_lo_q;
    assign STUCK_HI = stuck_hi_q;
    assign FMT_ERR  = fmt_err_q;

endmodule
